// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch pointer feeding a 2-entry {word, pc} buffer with branch decode of the head entry
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   imem_addr / imem_rd   combinational instruction memory (address out, word back same cycle)
//   stall                 consumer holds the head entry
//   redirect, redirect_pc flush buffer and restart fetching at redirect_pc (word aligned)
//   instr, instr_pc, instr_valid            head entry, zeroed when empty
//   is_branch, is_bl, link_addr, branch_target  decode of the head entry, zeroed when empty
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        is_branch,
    output logic        is_bl,
    output logic [31:0] link_addr,
    output logic [31:0] branch_target
);
    logic [31:0] fpc_q, fpc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] w0_q, w0_d, p0_q, p0_d, w1_q, w1_d, p1_q, p1_d;
    logic        pop, push, head_br;
    logic [31:0] head_off;
    assign pop  = (cnt_q != 2'd0) && !stall;
    assign push = (cnt_q != 2'd2) || pop;
    assign imem_addr = fpc_q;
    always_comb begin
        fpc_d = fpc_q;
        cnt_d = cnt_q;
        w0_d  = w0_q;
        p0_d  = p0_q;
        w1_d  = w1_q;
        p1_d  = p1_q;
        if (reset) begin
            fpc_d = RESET_PC & ~32'd3;
            cnt_d = 2'd0;
        end else if (redirect) begin
            fpc_d = redirect_pc & ~32'd3;
            cnt_d = 2'd0;
        end else begin
            fpc_d = push ? fpc_q + 32'd4 : fpc_q;
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
            // slot 0 is always the head; a pop shifts slot 1 down or takes the new word directly
            w0_d = pop ? (cnt_q == 2'd2 ? w1_q : imem_rd) : (cnt_q == 2'd0 ? imem_rd : w0_q);
            p0_d = pop ? (cnt_q == 2'd2 ? p1_q : fpc_q)   : (cnt_q == 2'd0 ? fpc_q   : p0_q);
            // slot 1 receives the new word when it lands behind a surviving head
            if ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop)) begin
                w1_d = imem_rd;
                p1_d = fpc_q;
            end
        end
    end
    always_ff @(posedge clk) begin
        fpc_q <= fpc_d;
        cnt_q <= cnt_d;
        w0_q  <= w0_d;
        p0_q  <= p0_d;
        w1_q  <= w1_d;
        p1_q  <= p1_d;
    end
    assign head_br  = w0_q[27:25] == 3'b101;
    assign head_off = {{6{w0_q[23]}}, w0_q[23:0], 2'b00};
    assign instr_valid   = cnt_q != 2'd0;
    assign instr         = instr_valid ? w0_q : 32'd0;
    assign instr_pc      = instr_valid ? p0_q : 32'd0;
    assign is_branch     = instr_valid && head_br;
    assign is_bl         = instr_valid && head_br && w0_q[24];
    assign link_addr     = instr_valid ? p0_q + 32'd4 : 32'd0;
    assign branch_target = instr_valid ? p0_q + 32'd8 + head_off : 32'd0;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized and directed checks of ifetch_unit against a queue-based fetch model
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1, stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr, imem_rd, instr, instr_pc, link_addr, branch_target;
    logic        instr_valid, is_branch, is_bl;
    logic        w_reset = 1'b1;
    logic [31:0] w_addr, w_rd, w_instr, w_pc, w_link, w_tgt;
    logic        w_valid, w_br, w_bl;
    logic [31:0] mem [64];
    logic [63:0] q [$];
    logic [31:0] m_fpc;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign imem_rd = mem[imem_addr[7:2]];
    assign w_rd    = mem[w_addr[7:2]];

    ifetch_unit u_dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .is_branch(is_branch), .is_bl(is_bl), .link_addr(link_addr), .branch_target(branch_target)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(w_reset), .imem_addr(w_addr), .imem_rd(w_rd),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'd0),
        .instr(w_instr), .instr_pc(w_pc), .instr_valid(w_valid),
        .is_branch(w_br), .is_bl(w_bl), .link_addr(w_link), .branch_target(w_tgt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] w, p, off;
        logic v;
        v   = q.size() > 0;
        w   = v ? q[0][63:32] : 32'd0;
        p   = v ? q[0][31:0]  : 32'd0;
        off = {{8{w[23]}}, w[23:0]};
        chk("valid", {31'd0, instr_valid}, {31'd0, v});
        chk("imem_addr", imem_addr, m_fpc);
        chk("instr", instr, w);
        chk("instr_pc", instr_pc, p);
        chk("is_branch", {31'd0, is_branch}, {31'd0, v && w[27:25] == 3'd5});
        chk("is_bl", {31'd0, is_bl}, {31'd0, v && w[27:25] == 3'd5 && w[24]});
        chk("link_addr", link_addr, v ? p + 32'd4 : 32'd0);
        chk("branch_target", branch_target, v ? p + 32'd8 + off * 32'd4 : 32'd0);
    endtask

    task automatic model_update();
        bit pop, full;
        if (reset) begin
            q.delete();
            m_fpc = 32'd0;
        end else if (redirect) begin
            q.delete();
            m_fpc = redirect_pc & ~32'd3;
        end else begin
            pop  = q.size() > 0 && !stall;
            full = q.size() == 2;
            if (pop) void'(q.pop_front());
            if (!full || pop) begin
                q.push_back({mem[m_fpc[7:2]], m_fpc});
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(0, 2) == 0) mem[i][27:25] = 3'b101;
        end
        mem[0] = 32'hEB00_0000;
        mem[1] = 32'hE280_0008;
        mem[2] = 32'hE041_1001;
        mem[3] = 32'hE240_0008;
        // branch at the top of memory whose target wraps to 0
        mem[63] = 32'hEAFF_FFFF;
        @(posedge clk);
        #1;
        q.delete();
        m_fpc = 32'd0;
        cyc();
        cyc();
        // straight-line fetch after reset
        reset = 1'b0;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        cyc();
        chk("p30_instr", instr, 32'hEB00_0000);
        chk("p30_bl", {31'd0, is_bl}, 32'd1);
        chk("p30_link", link_addr, 32'd4);
        chk("p30_tgt", branch_target, 32'd8);
        for (int i = 0; i < 4; i++) cyc();
        // redirect while the head is at pc 4
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        chk("rd_head", instr_pc, 32'd4);
        redirect = 1'b1;
        redirect_pc = 32'h0000_000E;
        cyc();
        redirect = 1'b0;
        chk("rd_gap_valid", {31'd0, instr_valid}, 32'd0);
        chk("rd_gap_addr", imem_addr, 32'hC);
        cyc();
        chk("rd_instr", instr, 32'hE240_0008);
        chk("rd_pc", instr_pc, 32'hC);
        // reset beats a simultaneous redirect
        reset = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'd8;
        cyc();
        reset = 1'b0;
        redirect = 1'b0;
        chk("rr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rr_addr", imem_addr, 32'd0);
        cyc();
        chk("rr_pc", instr_pc, 32'd0);
        // stall from release fills the buffer and freezes fetch
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("st_addr", imem_addr, 32'd8);
        chk("st_instr", instr, 32'hEB00_0000);
        cyc();
        chk("st_hold", imem_addr, 32'd8);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        // redirect wins over stall
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h10;
        cyc();
        redirect = 1'b0;
        chk("sr_valid", {31'd0, instr_valid}, 32'd0);
        cyc();
        stall = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 49) == 0;
            redirect = $urandom_range(0, 19) == 0;
            redirect_pc = $urandom_range(0, 5) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            stall = $urandom_range(0, 2) == 0;
            cyc();
        end
        reset = 1'b0;
        redirect = 1'b0;
        stall = 1'b0;
        // fetch wrap from the last word of the address space
        w_reset = 1'b1;
        @(posedge clk);
        #1;
        w_reset = 1'b0;
        chk("wr_addr0", w_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        chk("wr_instr", w_instr, 32'hEAFF_FFFF);
        chk("wr_pc", w_pc, 32'hFFFF_FFFC);
        chk("wr_tgt", w_tgt, 32'd0);
        chk("wr_addr1", w_addr, 32'd0);
        @(posedge clk);
        #1;
        chk("wr_next_pc", w_pc, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
